// File: rtl/maxpool_relu_pkg.sv
// Constants and FSM encodings shared by the CNN pipeline stages
// (conv stage and max-pool/ReLU stage).
package maxpool_relu_pkg;

    localparam int CNN_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pool_state_e;

endpackage

// File: rtl/pool_rowbuf.sv
// Half-row buffer for 2x2 pooling: holds the horizontal maxima of the even row
// until the matching odd row arrives. Single port, sync write, async read.
module pool_rowbuf
    import maxpool_relu_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int DEPTH  = 2,
    parameter int AW     = 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Contents are intentionally not reset: every entry is written in the even
    // row before the odd row reads it.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/maxpool_relu.sv
// 2x2 stride-2 max-pool with optional ReLU in front, fed one conv result per
// accepted cycle in raster order; one pooled result per 2x2 window.
module maxpool_relu
    import maxpool_relu_pkg::*;
#(
    parameter int DATA_W  = CNN_DATA_W,
    parameter int FMAP_W  = 26,
    parameter int FMAP_H  = 26,
    parameter int RELU_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     drop_err,
    output pool_state_e              state_dbg
);

    localparam int COL_W    = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
    localparam int ROW_W    = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;
    localparam int RB_DEPTH = (FMAP_W / 2 > 0) ? FMAP_W / 2 : 1;
    localparam int RB_AW    = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FMAP_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FMAP_H - 1);

    pool_state_e              state_q, state_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic signed [DATA_W-1:0] h_q, h_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     drop_err_q, drop_err_d;

    logic signed [DATA_W-1:0] x, hm, pooled, rb_rdata;
    logic                     rb_we;
    logic [RB_AW-1:0]         rb_addr;

    // Ties resolve to the earlier operand (h before x, row buffer before hm).
    always_comb begin
        x = in_data;
        if ((RELU_EN != 0) && in_data[DATA_W-1]) begin
            x = '0;
        end
        hm     = (x > h_q) ? x : h_q;
        pooled = (hm > rb_rdata) ? hm : rb_rdata;
    end

    assign rb_addr = RB_AW'(col_q >> 1);

    pool_rowbuf #(
        .DATA_W (DATA_W),
        .DEPTH  (RB_DEPTH),
        .AW     (RB_AW)
    ) u_rowbuf (
        .clk     (clk),
        .we_i    (rb_we),
        .addr_i  (rb_addr),
        .wdata_i (hm),
        .rdata_o (rb_rdata)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        h_d         = h_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        drop_err_d  = drop_err_q;
        rb_we       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    col_d      = '0;
                    row_d      = '0;
                    drop_err_d = in_valid;
                end else if (in_valid) begin
                    drop_err_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    // Odd trailing column/row of an odd-sized map is even-indexed,
                    // so it only ever lands in h or the row buffer.
                    if (!col_q[0]) begin
                        h_d = x;
                    end else if (!row_q[0]) begin
                        rb_we = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = pooled;
                    end
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (in_valid) begin
                    drop_err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            h_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            h_q         <= h_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = (state_q == ST_RUN);
    assign frame_done = (state_q == ST_DONE);
    assign drop_err   = drop_err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_maxpool_relu.sv
// Directed bench for maxpool_relu: 4x4 (ReLU on/off), 5x5 and 26x26 instances
// share one stimulus stream; each scenario checks the instance it targets.
module tb_maxpool_relu;
    import maxpool_relu_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic signed [W-1:0] in_data = '0;

    logic a_out_valid, a_busy, a_frame_done, a_drop_err;
    logic b_out_valid, b_busy, b_frame_done, b_drop_err;
    logic c_out_valid, c_busy, c_frame_done, c_drop_err;
    logic d_out_valid, d_busy, d_frame_done, d_drop_err;
    logic signed [W-1:0] a_out_data, b_out_data, c_out_data, d_out_data;
    pool_state_e a_state, b_state, c_state, d_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    maxpool_relu #(.DATA_W(W), .FMAP_W(4), .FMAP_H(4), .RELU_EN(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .out_valid(a_out_valid), .out_data(a_out_data), .busy(a_busy),
        .frame_done(a_frame_done), .drop_err(a_drop_err), .state_dbg(a_state));
    maxpool_relu #(.DATA_W(W), .FMAP_W(4), .FMAP_H(4), .RELU_EN(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .out_valid(b_out_valid), .out_data(b_out_data), .busy(b_busy),
        .frame_done(b_frame_done), .drop_err(b_drop_err), .state_dbg(b_state));
    maxpool_relu #(.DATA_W(W), .FMAP_W(5), .FMAP_H(5), .RELU_EN(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .out_valid(c_out_valid), .out_data(c_out_data), .busy(c_busy),
        .frame_done(c_frame_done), .drop_err(c_drop_err), .state_dbg(c_state));
    maxpool_relu #(.DATA_W(W), .FMAP_W(26), .FMAP_H(26), .RELU_EN(1)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .out_valid(d_out_valid), .out_data(d_out_data), .busy(d_busy),
        .frame_done(d_frame_done), .drop_err(d_drop_err), .state_dbg(d_state));

    // ---------------- model helpers ----------------
    function automatic bit pool_hit(input int idx, input int w);
        return (((idx % w) % 2) == 1) && (((idx / w) % 2) == 1);
    endfunction

    function automatic logic signed [W-1:0] relu(input logic signed [W-1:0] v);
        return (v < 0) ? '0 : v;
    endfunction

    function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
        return (b > a) ? b : a;
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic v, input logic signed [W-1:0] d);
        start    = st;
        in_valid = v;
        in_data  = d;
        step();
    endtask

    task automatic apply_reset();
        start = 1'b0; in_valid = 1'b0; in_data = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        step(); step();
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({a_out_valid, a_busy, a_frame_done, a_drop_err} !== 4'b0) begin
            n_bad++; $display("FAIL reset_flags_a: got %b want 0000", {a_out_valid, a_busy, a_frame_done, a_drop_err});
        end
        n_cmp++; if (a_out_data !== 16'sd0) begin
            n_bad++; $display("FAIL reset_data_a: got %0d want 0", a_out_data);
        end
        n_cmp++; if (a_state !== ST_IDLE) begin
            n_bad++; $display("FAIL reset_state_a: got %0d want %0d", a_state, ST_IDLE);
        end
        n_cmp++; if ({d_out_valid, d_busy, d_frame_done, d_drop_err} !== 4'b0) begin
            n_bad++; $display("FAIL reset_flags_d: got %b want 0000", {d_out_valid, d_busy, d_frame_done, d_drop_err});
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        logic hit;
        logic [W-1:0] e;
        apply_reset();
        exp_q = {16'd6, 16'd8, 16'd14, 16'd16};
        drive(1'b1, 1'b0, '0);
        n_cmp++; if (a_busy !== 1'b1) begin
            n_bad++; $display("FAIL b2b_busy: got %b want 1", a_busy);
        end
        for (int i = 1; i <= 16; i++) begin
            drive(i == 3, 1'b1, W'(i));   // start while running must be ignored
            hit = pool_hit(i - 1, 4);
            n_cmp++; if (a_out_valid !== hit) begin
                n_bad++; $display("FAIL b2b_valid px%0d: got %b want %b", i, a_out_valid, hit);
            end
            if (hit && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (a_out_data !== e) begin
                    n_bad++; $display("FAIL b2b_data px%0d: got %0d want %0d", i, a_out_data, e);
                end
            end
            n_cmp++; if (a_frame_done !== 1'(i == 16)) begin
                n_bad++; $display("FAIL b2b_done px%0d: got %b want %b", i, a_frame_done, i == 16);
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL b2b_count: %0d outputs missing want 0", exp_q.size());
        end
        drive(1'b0, 1'b0, '0);
        n_cmp++; if ({a_out_valid, a_frame_done, a_busy} !== 3'b000) begin
            n_bad++; $display("FAIL b2b_idle_flags: got %b want 000", {a_out_valid, a_frame_done, a_busy});
        end
        n_cmp++; if (a_out_data !== 16'sd16) begin
            n_bad++; $display("FAIL b2b_hold: got %0d want 16", a_out_data);
        end
        n_cmp++; if (a_state !== ST_IDLE) begin
            n_bad++; $display("FAIL b2b_state: got %0d want %0d", a_state, ST_IDLE);
        end
    endtask

    task automatic test_relu();
        logic hit;
        apply_reset();
        drive(1'b1, 1'b0, '0);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b1, -16'sd5);
            hit = pool_hit(i - 1, 4);
            n_cmp++; if (a_out_valid !== hit || b_out_valid !== hit) begin
                n_bad++; $display("FAIL relu_valid px%0d: got %b/%b want %b", i, a_out_valid, b_out_valid, hit);
            end
            if (hit) begin
                n_cmp++; if (a_out_data !== 16'sd0) begin
                    n_bad++; $display("FAIL relu_on px%0d: got %0d want 0", i, a_out_data);
                end
                n_cmp++; if (b_out_data !== -16'sd5) begin
                    n_bad++; $display("FAIL relu_off px%0d: got %0d want -5", i, b_out_data);
                end
            end
        end
        n_cmp++; if (b_frame_done !== 1'b1) begin
            n_bad++; $display("FAIL relu_done: got %b want 1", b_frame_done);
        end
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_odd_dims();
        logic hit;
        logic [W-1:0] e;
        int n_out;
        apply_reset();
        exp_q = {16'd7, 16'd9, 16'd17, 16'd19};
        n_out = 0;
        drive(1'b1, 1'b0, '0);
        for (int i = 1; i <= 25; i++) begin
            drive(1'b0, 1'b1, W'(i));
            hit = pool_hit(i - 1, 5);
            n_cmp++; if (c_out_valid !== hit) begin
                n_bad++; $display("FAIL odd_valid px%0d: got %b want %b", i, c_out_valid, hit);
            end
            if (c_out_valid) n_out++;
            if (hit && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (c_out_data !== e) begin
                    n_bad++; $display("FAIL odd_data px%0d: got %0d want %0d", i, c_out_data, e);
                end
            end
            n_cmp++; if (c_frame_done !== 1'(i == 25)) begin
                n_bad++; $display("FAIL odd_done px%0d: got %b want %b", i, c_frame_done, i == 25);
            end
        end
        n_cmp++; if (n_out != 4) begin
            n_bad++; $display("FAIL odd_count: got %0d want 4", n_out);
        end
        drive(1'b0, 1'b0, '0);
        n_cmp++; if ({c_busy, c_frame_done, c_out_valid} !== 3'b000) begin
            n_bad++; $display("FAIL odd_idle: got %b want 000", {c_busy, c_frame_done, c_out_valid});
        end
    endtask

    task automatic test_drop();
        logic hit;
        logic [W-1:0] e;
        apply_reset();
        drive(1'b0, 1'b1, 16'sd99);
        n_cmp++; if ({a_drop_err, a_busy} !== 2'b10) begin
            n_bad++; $display("FAIL drop_idle: got %b want 10", {a_drop_err, a_busy});
        end
        drive(1'b1, 1'b0, '0);
        n_cmp++; if ({a_drop_err, a_busy} !== 2'b01) begin
            n_bad++; $display("FAIL drop_clear: got %b want 01", {a_drop_err, a_busy});
        end
        for (int pass = 0; pass < 2; pass++) begin
            exp_q = {16'd6, 16'd8, 16'd14, 16'd16};
            for (int i = 1; i <= 16; i++) begin
                drive(1'b0, 1'b1, W'(i));
                hit = pool_hit(i - 1, 4);
                n_cmp++; if (a_out_valid !== hit) begin
                    n_bad++; $display("FAIL drop_valid p%0d px%0d: got %b want %b", pass, i, a_out_valid, hit);
                end
                if (hit && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_cmp++; if (a_out_data !== e) begin
                        n_bad++; $display("FAIL drop_data p%0d px%0d: got %0d want %0d", pass, i, a_out_data, e);
                    end
                end
            end
            if (pass == 0) begin
                drive(1'b0, 1'b1, 16'sd55);   // pixel during DONE
                n_cmp++; if ({a_drop_err, a_state} !== {1'b1, ST_IDLE}) begin
                    n_bad++; $display("FAIL drop_done: got %b/%0d want 1/%0d", a_drop_err, a_state, ST_IDLE);
                end
                drive(1'b1, 1'b1, 16'sd77);   // start with a pixel: pixel discarded
                n_cmp++; if ({a_drop_err, a_busy} !== 2'b11) begin
                    n_bad++; $display("FAIL drop_start_px: got %b want 11", {a_drop_err, a_busy});
                end
            end
        end
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        n_cmp++; if (a_drop_err !== 1'b0) begin
            n_bad++; $display("FAIL drop_next_start: got %b want 0", a_drop_err);
        end
    endtask

    task automatic test_reset_mid();
        logic hit;
        logic [W-1:0] e;
        apply_reset();
        drive(1'b1, 1'b0, '0);
        for (int i = 1; i <= 7; i++) drive(1'b0, 1'b1, W'(i));
        n_cmp++; if (a_out_data !== 16'sd6) begin
            n_bad++; $display("FAIL mid_pre: got %0d want 6", a_out_data);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({a_out_valid, a_busy, a_frame_done, a_drop_err} !== 4'b0 || a_out_data !== 16'sd0) begin
            n_bad++; $display("FAIL mid_reset: got %b data %0d want 0000 data 0",
                              {a_out_valid, a_busy, a_frame_done, a_drop_err}, a_out_data);
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, '0);
            n_cmp++; if ({a_out_valid, a_frame_done, a_busy} !== 3'b000) begin
                n_bad++; $display("FAIL mid_quiet c%0d: got %b want 000", k, {a_out_valid, a_frame_done, a_busy});
            end
        end
        exp_q = {16'd6, 16'd8, 16'd14, 16'd16};
        drive(1'b1, 1'b0, '0);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b1, W'(i));
            hit = pool_hit(i - 1, 4);
            n_cmp++; if (a_out_valid !== hit || a_frame_done !== 1'(i == 16)) begin
                n_bad++; $display("FAIL mid_frame px%0d: got %b%b want %b%b", i, a_out_valid, a_frame_done, hit, i == 16);
            end
            if (hit && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (a_out_data !== e) begin
                    n_bad++; $display("FAIL mid_data px%0d: got %0d want %0d", i, a_out_data, e);
                end
            end
        end
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_cadence_26();
        logic signed [W-1:0] pix [676];
        logic signed [W-1:0] m;
        logic [W-1:0] e;
        logic hit;
        int n_pulse, n_done;
        apply_reset();
        for (int k = 0; k < 676; k++) pix[k] = W'(int'($urandom_range(0, 600)) - 300);
        exp_q.delete();
        for (int r = 1; r < 26; r += 2) begin
            for (int c = 1; c < 26; c += 2) begin
                m = relu(pix[(r - 1) * 26 + c - 1]);
                m = smax(m, relu(pix[(r - 1) * 26 + c]));
                m = smax(m, relu(pix[r * 26 + c - 1]));
                m = smax(m, relu(pix[r * 26 + c]));
                exp_q.push_back(m);
            end
        end
        n_pulse = 0;
        n_done = 0;
        drive(1'b1, 1'b0, '0);
        for (int k = 0; k < 676; k++) begin
            drive(1'b0, 1'b1, pix[k]);
            hit = pool_hit(k, 26);
            if (d_out_valid) n_pulse++;
            if (d_frame_done) n_done++;
            n_cmp++; if (d_out_valid !== hit) begin
                n_bad++; $display("FAIL cad_valid px%0d: got %b want %b", k, d_out_valid, hit);
            end
            if (hit && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (d_out_data !== e) begin
                    n_bad++; $display("FAIL cad_data px%0d: got %0d want %0d", k, d_out_data, $signed(e));
                end
            end
            for (int g = 0; g < 9; g++) begin
                drive(1'b0, 1'b0, '0);
                if (d_out_valid) n_pulse++;
                if (d_frame_done) n_done++;
            end
        end
        n_cmp++; if (n_pulse != 169) begin
            n_bad++; $display("FAIL cad_pulses: got %0d want 169", n_pulse);
        end
        n_cmp++; if (n_done != 1) begin
            n_bad++; $display("FAIL cad_done: got %0d want 1", n_done);
        end
        n_cmp++; if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL cad_left: got %0d want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_relu();
        test_odd_dims();
        test_drop();
        test_reset_mid();
        test_cadence_26();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
